burst_memory: RTL

Parameterised, byte-addressed, little-endian data memory with a start/ready handshake, variable access latency, multi-beat bursts and per-byte write strobes. It sits behind the processor's load/store unit, and behind any bus master that needs multi-word transfers. After reset it clears its array with a hardware sweep, one word per cycle. A combinational debug read port gives testbenches direct visibility of memory contents.

---
 rtl/burst_memory_if.sv | 29 ++
 rtl/burst_memory.sv | 111 +++++++++++
 2 files changed

// File: rtl/burst_memory_if.sv
// Request/response bundle between a bus master and burst_memory.
// Signal widths follow the word size (BYTES) and the burst-length field (MAX_BURST).
interface burst_memory_if #(
  parameter int BYTES     = 4,
  parameter int MAX_BURST = 4
) ();
  localparam int LEN_W = $clog2(MAX_BURST);

  logic                 start;
  logic                 rwn;
  logic [31:0]          address;
  logic [LEN_W-1:0]     burst_len;
  logic [8*BYTES-1:0]   wdata;
  logic [BYTES-1:0]     wstrb;
  logic                 ready;
  logic                 wreq;
  logic [8*BYTES-1:0]   rdata;
  logic                 rvalid;

  modport master (
    output start, rwn, address, burst_len, wdata, wstrb,
    input  ready, wreq, rdata, rvalid
  );

  modport slave (
    input  start, rwn, address, burst_len, wdata, wstrb,
    output ready, wreq, rdata, rvalid
  );
endinterface

// File: rtl/burst_memory.sv
// Byte-addressed little-endian memory with start/ready handshake, wait states,
// wrapping multi-beat bursts, byte strobes, and a post-reset clearing sweep.
module burst_memory #(
  parameter int ADDR_W    = 16,
  parameter int BYTES     = 4,
  parameter int BASE_LAT  = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  burst_memory_if.slave       bus,
  input  logic [31:0]         dbg_addr,
  output logic [8*BYTES-1:0]  dbg_data
);
  localparam int OFF_W = $clog2(BYTES);
  localparam int LEN_W = $clog2(MAX_BURST);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int CNT_W = $clog2(BASE_LAT + BYTES);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {INIT, IDLE, WAIT, BEAT} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    clr_idx;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_load;
  logic [LEN_W-1:0]    beat_idx;
  logic [LEN_W-1:0]    len;
  logic [ADDR_W-1:0]   base;
  logic [ADDR_W-1:0]   beat_base;
  logic                op_read;
  logic [8*BYTES-1:0]  beat_word;
  logic [8*BYTES-1:0]  rd_word;
  logic                rd_valid;
  logic [7:0]          mem [DEPTH];

  wire unused_bits = ^{bus.address[31:ADDR_W], dbg_addr[31:ADDR_W]};

  // Misaligned starts pay one extra wait cycle per byte of offset.
  assign wait_load = CNT_W'(BASE_LAT) + CNT_W'(bus.address[OFF_W-1:0]);
  assign beat_base = base + (ADDR_W'(beat_idx) << OFF_W);

  assign bus.ready  = (state == IDLE);
  assign bus.wreq   = (state == BEAT) && !op_read;
  assign bus.rdata  = rd_word;
  assign bus.rvalid = rd_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      INIT: if (clr_idx == '1) state_nxt = IDLE;
      IDLE: if (bus.start) state_nxt = (wait_load != '0) ? WAIT : BEAT;
      WAIT: if (wait_cnt == CNT_W'(1)) state_nxt = BEAT;
      BEAT: if (beat_idx == len) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      clr_idx  <= '0;
      wait_cnt <= '0;
      beat_idx <= '0;
      len      <= '0;
      base     <= '0;
      op_read  <= 1'b0;
      rd_word  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= (state == BEAT) && op_read;
      case (state)
        INIT: clr_idx <= clr_idx + 1'b1;
        IDLE: if (bus.start) begin
          op_read  <= bus.rwn;
          base     <= bus.address[ADDR_W-1:0];
          len      <= bus.burst_len;
          wait_cnt <= wait_load;
          beat_idx <= '0;
        end
        WAIT: wait_cnt <= wait_cnt - 1'b1;
        BEAT: begin
          if (op_read) rd_word <= beat_word;
          beat_idx <= beat_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Byte lanes wrap independently at the top of the array.
  always_comb begin
    beat_word = '0;
    dbg_data  = '0;
    for (int i = 0; i < BYTES; i++) begin
      beat_word[8*i +: 8] = mem[beat_base + ADDR_W'(i)];
      dbg_data[8*i +: 8]  = mem[dbg_addr[ADDR_W-1:0] + ADDR_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      for (int i = 0; i < BYTES; i++)
        mem[{clr_idx, OFF_W'(i)}] <= 8'h00;
    end else if (bus.wreq) begin
      for (int i = 0; i < BYTES; i++)
        if (bus.wstrb[i]) mem[beat_base + ADDR_W'(i)] <= bus.wdata[8*i +: 8];
    end
  end
endmodule
